// File: rtl/tetris_key_cmd.sv
// tetris_key_cmd: turns debounced key pulses into a buffered game-command stream.
// Per-key pending bits merge events. A fixed-priority arbiter moves them into a
// small FIFO, and the FIFO drains through a valid/ready handshake.
// Define TETRIS_AUTOREPEAT_EN to build the hold-to-repeat (delayed auto-shift) FSM
// for left/right/down. Without it, only key_pulse creates events.
module tetris_key_cmd #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = 25,
  parameter int unsigned DAS_CYCLES = 20_000_000,
  parameter int unsigned RPT_CYCLES = 5_000_000
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic [3:0]               key_pulse,
  input  logic [3:0]               key_level,
  output logic                     cmd_valid,
  output logic [1:0]               cmd_code,
  input  logic                     cmd_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Repeat ticks, one bit per key (rotate never repeats)
  logic [3:0] rpt_ev;
  logic [3:0] key_ev;

`ifdef TETRIS_AUTOREPEAT_EN
  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rpt_state_e;

  localparam logic [CNT_W-1:0] DasLast = CNT_W'(DAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] RptLast = CNT_W'(RPT_CYCLES - 1);

  rpt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       own_q, own_d;

  // Repeat FSM state, shared timer and owner key
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      own_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      own_q   <= own_d;
    end
  end

  // A fresh move-key press always restarts the delay; release beats a same-cycle tick
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    own_d   = own_q;
    rpt_ev  = '0;
    if (|key_pulse[2:0]) begin
      state_d = StDelay;
      cnt_d   = '0;
      if (key_pulse[0])      own_d = 2'd0;
      else if (key_pulse[1]) own_d = 2'd1;
      else                   own_d = 2'd2;
    end else begin
      unique case (state_q)
        StIdle: ;
        StDelay: begin
          if (!key_level[own_q]) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == DasLast) begin
            rpt_ev[own_q] = 1'b1;
            cnt_d         = '0;
            state_d       = StRepeat;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StRepeat: begin
          if (!key_level[own_q]) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == RptLast) begin
            rpt_ev[own_q] = 1'b1;
            cnt_d         = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end
`else
  logic unused_cfg;

  // No auto-repeat: levels and timer settings are not needed
  always_comb begin
    rpt_ev     = '0;
    unused_cfg = ^{key_level, CNT_W[0], DAS_CYCLES[0], RPT_CYCLES[0]};
  end
`endif

  logic [3:0]    pend_q, pend_d;
  logic [3:0]    grant;
  logic [1:0]    grant_code;
  logic          push, pop, can_wr;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    mem_q [DEPTH];

  // Arbitration, pending-bit update and FIFO pointer/count next state
  always_comb begin
    key_ev     = key_pulse | rpt_ev;
    pop        = (count_q != '0) && cmd_ready;
    can_wr     = (count_q < CW'(DEPTH)) || pop;
    grant      = '0;
    grant_code = 2'd0;
    if (pend_q[0]) begin
      grant[0] = 1'b1;  grant_code = 2'd0;
    end else if (pend_q[1]) begin
      grant[1] = 1'b1;  grant_code = 2'd1;
    end else if (pend_q[2]) begin
      grant[2] = 1'b1;  grant_code = 2'd2;
    end else if (pend_q[3]) begin
      grant[3] = 1'b1;  grant_code = 2'd3;
    end
    if (!can_wr) grant = '0;
    push = |grant;
    // A new event on the granted key re-sets its bit in the same cycle
    pend_d   = (pend_q & ~grant) | key_ev;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // Pending bits, FIFO storage and pointers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      pend_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 2'd0;
    end else begin
      pend_q   <= pend_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= grant_code;
    end
  end

  // Head of the FIFO is presented combinationally; code reads 0 when empty
  always_comb begin
    cmd_valid  = (count_q != '0);
    cmd_code   = cmd_valid ? mem_q[rd_ptr_q] : 2'd0;
    fifo_count = count_q;
  end

endmodule
